ksa_mp_sequencer: RTL and testbench
===================================

Name: ksa_mp_sequencer

Overview:
- Multi-precision add/subtract sequencer built around one shared 16-bit Kogge-Stone slice, `ksa16b_simple`.
- Accepts WORDS×16-bit operands over a valid/ready handshake and processes one 16-bit word per clock, LSW first.
- The carry is registered between words.
- Presents the full result, carry/borrow-out and signed overflow on an output valid/ready handshake.
- Sits between the operand source (register file or DMA front end) and any consumer that needs 32/64/128-bit arithmetic without a wide adder.

Parameters:
- WORDS, 4, number of 16-bit words per operand (legal range 2..16). Operand width = 16*WORDS.
- SLICE_W, 16, adder slice width. Fixed to match `ksa16b_simple`; any other value is a compile-time error.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand set valid.
- in_ready  out  1  sequencer can accept an operand set.
- op_a  in  16*WORDS  operand A.
- op_b  in  16*WORDS  operand B.
- sub  in  1  0 = A+B+cin; 1 = A-B-cin (cin acts as borrow-in).
- cin  in  1  carry-in (add) or borrow-in (sub).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- result  out  16*WORDS  sum or difference.
- cout  out  1  carry-out (add) or borrow-out (sub).
- ovf  out  1  two's-complement signed overflow.
- busy  out  1  high in RUN or DONE.

Behaviour:
- **Reset.** While rst is high: state=IDLE; result=0, cout=0, ovf=0, out_valid=0, busy=0; word index=0; carry register=0. Reset is asynchronous and aborts any operation in progress; no partial result is ever presented.
- **States and transitions:**
  - IDLE -> RUN on an edge with in_valid&in_ready.
  - RUN -> DONE on the edge that processes word WORDS-1.
  - DONE -> IDLE on an edge with out_valid&out_ready.
- **in_ready.** Equals (state==IDLE). There is no back-to-back acceptance: the earliest next accept is the edge after the result is taken.
- **Accept edge E0.** Register op_a and op_b (op_b stored as ~op_b when sub=1) and sub. Initialise carry = sub ? ~cin : cin. Set index=0.
- **RUN edges E1..E_WORDS.**
  - Slice inputs: a=A[idx], b=Beff[idx], cin=carry.
  - Register the slice sum into result[idx]; carry <= slice cout; idx++.
  - On the last word, also capture the top-word MSBs for ovf.
- **Latency.** out_valid rises after edge E_WORDS, i.e. WORDS cycles after acceptance (4 for the default).
- **Final outputs:**
  - cout = sub ? ~carry : carry.
  - ovf = (A_msb == Beff_msb) && (sum_msb != A_msb).
- **Hold in DONE.** result, cout, ovf and out_valid hold stable until out_ready. in_valid is ignored in RUN and DONE, and operand inputs are never sampled outside the accept edge.
- **Index.** Width is clog2(WORDS). It is cleared on accept and never wraps within an operation.
- **Result clearing.** result is not cleared on leaving DONE; it holds until overwritten word by word.

Decomposition:
- **Package ksa_mp_pkg:** state enum typedef (IDLE, RUN, DONE) and the SLICE_W=16 localparam.
- **Sub-module:** one instance of the existing `ksa16b_simple`, used as the shared slice. No other sub-modules; FSM, index counter, carry register and operand/result registers live in ksa_mp_sequencer.

Test Plan:
1. WORDS=4, add, cin=0: A=0x0001_0002_0003_0004, B=0x0005_0006_0007_0008 -> result=0x0006_0008_000A_000C, cout=0, ovf=0; out_valid high exactly 4 cycles after accept.
2. Full-width ripple: A=0xFFFF_FFFF_FFFF_FFFF, B=0x1, cin=0 -> result=0, cout=1, ovf=0. Same A, B=0, cin=1 gives the same response.
3. Subtract: sub=1, A=0, B=1, cin=0 -> result=0xFFFF_FFFF_FFFF_FFFF, cout(borrow)=1, ovf=0. Also A=0x10, B=0x10 -> result=0, cout=0.
4. Overflow: A=0x7FFF_FFFF_FFFF_FFFF, B=0x1, add -> result=0x8000_0000_0000_0000, ovf=1, cout=0. Also sub with A=0x8000_0000_0000_0000, B=1 -> 0x7FFF_FFFF_FFFF_FFFF, ovf=1.
5. Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid and operands -> result, cout and ovf stable, in_ready=0. On out_ready=1 -> IDLE next edge, in_ready=1.
6. Reset mid-RUN: assert rst asynchronously after E2 -> outputs immediately 0, busy=0. After release, a new add of 0x2+0x3 yields result=0x5 with 4-cycle latency.

Source files
------------

// File: rtl/ksa_mp_pkg.sv
// Shared types and constants for the multi-precision add/subtract sequencer.
package ksa_mp_pkg;

    localparam int SLICE_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/ksa16b_simple.sv
// 16-bit Kogge-Stone adder slice with carry-in folded into the bit-0 generate.
module ksa16b_simple (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);

    logic [15:0] prop0;
    logic [15:0] gen_pre;

    assign prop0 = a ^ b;

    // Four prefix levels (span 1, 2, 4, 8); gen_pre[i] is the carry out of bit i.
    always_comb begin : prefix_tree
        logic [15:0] g_cur;
        logic [15:0] p_cur;
        logic [15:0] g_nxt;
        logic [15:0] p_nxt;
        g_cur    = a & b;
        g_cur[0] = g_cur[0] | (prop0[0] & cin);
        p_cur    = prop0;
        g_nxt    = g_cur;
        p_nxt    = p_cur;
        for (int lv = 0; lv < 4; lv++) begin
            g_nxt = g_cur;
            p_nxt = p_cur;
            for (int i = (1 << lv); i < 16; i++) begin
                g_nxt[i] = g_cur[i] | (p_cur[i] & g_cur[i - (1 << lv)]);
                p_nxt[i] = p_cur[i] & p_cur[i - (1 << lv)];
            end
            g_cur = g_nxt;
            p_cur = p_nxt;
        end
        gen_pre = g_cur;
    end

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_sum
            if (gi == 0) begin : g_lsb
                assign sum[gi] = prop0[gi] ^ cin;
            end else begin : g_upper
                assign sum[gi] = prop0[gi] ^ gen_pre[gi-1];
            end
        end
    endgenerate

    assign cout = gen_pre[15];

endmodule

// File: rtl/ksa_mp_sequencer.sv
// Multi-precision add/subtract: one shared 16-bit slice, one word per clock, LSW first.
module ksa_mp_sequencer
    import ksa_mp_pkg::*;
#(
    parameter int WORDS   = 4,
    parameter int SLICE_W = ksa_mp_pkg::SLICE_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [16*WORDS-1:0]      op_a,
    input  logic [16*WORDS-1:0]      op_b,
    input  logic                     sub,
    input  logic                     cin,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [16*WORDS-1:0]      result,
    output logic                     cout,
    output logic                     ovf,
    output logic                     busy
);

    localparam int W     = 16 * WORDS;
    localparam int IDX_W = $clog2(WORDS);

    generate
        if (SLICE_W != 16) begin : g_bad_slice
            $error("ksa_mp_sequencer: SLICE_W must be 16 to match ksa16b_simple");
        end
        if (WORDS < 2 || WORDS > 16) begin : g_bad_words
            $error("ksa_mp_sequencer: WORDS must be in 2..16");
        end
    endgenerate

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   idx_reg;
    logic [W-1:0]       a_reg, b_reg, result_reg;
    logic               sub_reg, carry_reg, cout_reg, ovf_reg;
    logic [15:0]        slice_a, slice_b, slice_sum;
    logic               slice_cout;
    logic               last_word;

    assign last_word = (idx_reg == IDX_W'(WORDS - 1));
    assign slice_a   = a_reg[idx_reg*16 +: 16];
    assign slice_b   = b_reg[idx_reg*16 +: 16];

    ksa16b_simple u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_reg),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid)  state_next = RUN;
            RUN:     if (last_word) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // Subtraction runs as A + ~B + ~borrow_in; the final carry is inverted back into a borrow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_reg    <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            result_reg <= '0;
            sub_reg    <= 1'b0;
            carry_reg  <= 1'b0;
            cout_reg   <= 1'b0;
            ovf_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_reg     <= op_a;
                        b_reg     <= sub ? ~op_b : op_b;
                        sub_reg   <= sub;
                        carry_reg <= sub ? ~cin : cin;
                        idx_reg   <= '0;
                    end
                end
                RUN: begin
                    result_reg[idx_reg*16 +: 16] <= slice_sum;
                    carry_reg                    <= slice_cout;
                    if (last_word) begin
                        cout_reg <= sub_reg ^ slice_cout;
                        ovf_reg  <= (slice_a[15] == slice_b[15]) && (slice_sum[15] != slice_a[15]);
                    end else begin
                        idx_reg <= idx_reg + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign busy      = (state_reg != IDLE);
    assign result    = result_reg;
    assign cout      = cout_reg;
    assign ovf       = ovf_reg;

endmodule

// File: tb/tb_ksa_mp_sequencer.sv
// Scoreboard bench for ksa_mp_sequencer (WORDS=4): directed vectors, decoupled monitor.
module tb_ksa_mp_sequencer;

    localparam int WORDS = 4;
    localparam int W     = 16 * WORDS;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         sub;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;
    logic         busy;

    typedef struct {
        logic [W-1:0] res;
        logic         co;
        logic         ov;
        int           id;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;
    int   txn_id = 0;

    ksa_mp_sequencer #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .sub       (sub),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per output handshake.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got result %h with empty scoreboard", result);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("txn_result", result, e.res);
                check("txn_cout", 64'(cout), 64'(e.co));
                check("txn_ovf", 64'(ovf), 64'(e.ov));
                $display("txn %0d: result=%h cout=%0d ovf=%0d (exp %h/%0d/%0d)",
                         e.id, result, cout, ovf, e.res, e.co, e.ov);
            end
        end
    end

    // Enters and leaves aligned 1 time unit after a rising edge.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input logic c,
                          input logic [W-1:0] er, input logic eco, input logic eov, input int hold);
        int   n;
        exp_t e;
        e.res = er; e.co = eco; e.ov = eov; e.id = txn_id++;
        sb_q.push_back(e);
        out_ready = (hold == 0);
        op_a = a; op_b = b; sub = s; cin = c; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
        check("accept_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        op_a = {$urandom, $urandom};
        op_b = {$urandom, $urandom};
        n = 0;
        while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
        check("latency", 64'(n), 64'(WORDS));
        for (int k = 0; k < hold; k++) begin
            in_valid = k[0];
            op_a = ~a; op_b = ~b; sub = ~s;
            @(negedge clk);
            check("hold_in_ready", 64'(in_ready), 64'd0);
            check("hold_out_valid", 64'(out_valid), 64'd1);
            check("hold_result", result, er);
            check("hold_cout", 64'(cout), 64'(eco));
            check("hold_ovf", 64'(ovf), 64'(eov));
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("release_in_ready", 64'(in_ready), 64'd1);
        check("release_out_valid", 64'(out_valid), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op_a = '0; op_b = '0; sub = 1'b0; cin = 1'b0;
        #12;
        check("rst_result", result, 64'd0);
        check("rst_cout", 64'(cout), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        run_op(64'h0001_0002_0003_0004, 64'h0005_0006_0007_0008, 1'b0, 1'b0,
               64'h0006_0008_000A_000C, 1'b0, 1'b0, 0);
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 0);
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0, 1'b1, 64'h0, 1'b1, 1'b0, 0);
        run_op(64'h0, 64'h1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 0);
        run_op(64'h10, 64'h10, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 0);
        run_op(64'h5, 64'h3, 1'b1, 1'b1, 64'h1, 1'b0, 1'b0, 0);
        run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 0);
        run_op(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 1'b1,
               64'h2345_6789_ABCD_F002, 1'b0, 1'b0, 5);
        run_op(64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 0);

        // Abort an operation after its second word has been written.
        op_a = 64'h1111_1111_1111_1111; op_b = 64'h2222_2222_2222_2222;
        sub = 1'b0; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("abort_result", result, 64'd0);
        check("abort_cout", 64'(cout), 64'd0);
        check("abort_ovf", 64'(ovf), 64'd0);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        run_op(64'h2, 64'h3, 1'b0, 1'b0, 64'h5, 1'b0, 1'b0, 0);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
